pinmux_wkup_detector: RTL and testbench
=======================================

# pinmux_wkup_detector

Wakeup detector on the pad input path, directly downstream of the pad attribute/pad wrapper stage: it consumes the raw pad input value and reports configurable wakeup conditions to the pinmux wakeup/interrupt logic. Each instance monitors one pad. It synchronizes the pad, optionally debounces it, and detects edges or timed levels. It emits a one-cycle event pulse and a sticky wakeup flag that software clears.

## Interface
- CntWidth, default 8: width of the timed-level counter and of `cnt_th_i`.
- FiltCycles, default 4: number of consecutive identical synchronized samples required before the filtered value changes. Must be ≥ 2.
- clk_i  input  1: clock.
- rst_ni  input  1: reset. Asynchronous, active-low.
- en_i  input  1: detector enable.
- mode_i  input  3: detection mode. The encodings are:
  - 3'd0 Posedge
  - 3'd1 Negedge
  - 3'd2 AnyEdge
  - 3'd3 TimedHigh
  - 3'd4 TimedLow
  - 3'd5–7 reserved, meaning no detection.
- filter_en_i  input  1: enables the debounce filter.
- cnt_th_i  input  CntWidth: timed-mode threshold in cycles. A value of 0 behaves as 1.
- clr_i  input  1: clears `wkup_o`.
- pad_i  input  1: asynchronous pad input value from the pad stage.
- event_o  output  1: one-cycle detection pulse. Registered.
- wkup_o  output  1: sticky wakeup flag. Registered.

## Operation
- **Synchronizer:** a 2-flop chain on `pad_i`, producing `sync_q`. It is always running and does not depend on `en_i`. Reset value is 0.
- **Filter (`filt_q`, reset 0):**
  - When `filter_en_i` = 0: `filt_q <= sync_q` every cycle.
  - When `filter_en_i` = 1: a stability counter `stab_q` resets to 0 whenever `sync_q` differs from its previous sample.
    - Otherwise `stab_q` increments, saturating at FiltCycles-1.
    - `filt_q <= sync_q` only when `stab_q` == FiltCycles-1.
  - Pulses shorter than FiltCycles cycles never reach `filt_q`.
- **Edge reference:** `prev_q <= filt_q` every cycle, regardless of `en_i`. Enabling the detector while the pad is already high therefore produces no edge.
- **Edge modes (0/1/2):**
  - Posedge: `event_o <= en_i & filt_q & ~prev_q`.
  - Negedge: `event_o <= en_i & ~filt_q & prev_q`.
  - AnyEdge: `event_o <= en_i & (filt_q ^ prev_q)`.
- **Timed modes (3/4):** the target level is 1 for TimedHigh and 0 for TimedLow. Let `th` = max(`cnt_th_i`, 1).
  - If `en_i` and `filt_q` == target level:
    - `cnt_q` increments, saturating at `th`.
    - `event_o <= (cnt_q + 1 == th)`, computed at CntWidth+1 bits.
  - Otherwise `cnt_q <= 0` and `event_o <= 0`.
  - There is exactly one pulse per contiguous hold period.
- **Mode change:** `mode_q` registers `mode_i`. When `mode_i` != `mode_q`, `cnt_q` is cleared and `event_o` is 0 for that cycle.
- **Reserved mode or `en_i` = 0:** `event_o` = 0 and `cnt_q` = 0.
- **Sticky flag:** `wkup_o <= (wkup_o & ~clr_i) | event_o`. When `clr_i` and `event_o` are both high in the same cycle, set wins.
- **Reset mid-operation:** all state returns to its reset value immediately, because reset is asynchronous. No event is generated on reset release, because `filt_q` and `prev_q` are both 0.

## Timing
- Reset values: `event_o` = 0, `wkup_o` = 0. All internal registers (`sync_q` chain, `stab_q`, `filt_q`, `prev_q`, `cnt_q`, `mode_q`) reset to 0.
- Edge latency, filter off: when `pad_i` changes before rising edge k, `event_o` is high in the cycle after edge k+3, i.e. 3 cycles later.
- Edge latency, filter on: the 3-cycle edge latency plus FiltCycles-1 cycles, which is 6 cycles at the default FiltCycles.
- Timed latency: if `filt_q` first holds the target level in cycle c, `event_o` is high in cycle c+th.
- `wkup_o` rises one cycle after `event_o`.
- `clr_i` takes effect on the next edge.
- Configuration inputs are sampled every cycle. Software changes `mode_i`, `filter_en_i` and `cnt_th_i` with `en_i` = 0. Changes made while enabled are legal and behave as specified above.

## Test plan
- **Posedge, filter off:** `en_i`=1, `mode_i`=0; raise `pad_i` → exactly one `event_o` pulse 3 cycles later and `wkup_o`=1 one cycle after it. Lowering `pad_i` → no pulse.
- **Filter rejection:** `filter_en_i`=1, AnyEdge; 3-cycle high glitch on `pad_i` → no event. A 10-cycle high pulse → two events, at +6 cycles after the rise and +6 cycles after the fall.
- **Timed high:** `mode_i`=3, `cnt_th_i`=5; hold `pad_i` high for 20 cycles → one pulse 5 cycles after `filt_q` rises. Releasing after 4 cycles → no pulse.
- **Threshold 0:** `mode_i`=4, `cnt_th_i`=0; drop `pad_i` → behaves as threshold 1, with the pulse 1 cycle after `filt_q` falls.
- **Sticky clear:** `clr_i` asserted in the same cycle as `event_o` → `wkup_o` stays 1. `clr_i` alone afterwards → `wkup_o`=0 on the next cycle.
- **Enable/mode/reset corner cases:**
  - With `pad_i` already high, set `en_i`=1 in Posedge mode → no event.
  - Switch `mode_i` mid-count in a timed mode → `cnt_q` restarts from 0.
  - Assert `rst_ni`=0 mid-count → `event_o`, `wkup_o` and `cnt_q` are 0 immediately.

Source files
------------

// File: rtl/pinmux_wkup_detector.sv
// Per-pad wakeup detector: synchronizer, optional debounce filter,
// then edge or timed-level detection feeding a sticky wakeup flag.
module pinmux_wkup_detector #(
    parameter int CntWidth   = 8,
    parameter int FiltCycles = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [2:0]          mode_i,
    input  logic                filter_en_i,
    input  logic [CntWidth-1:0] cnt_th_i,
    input  logic                clr_i,
    input  logic                pad_i,
    output logic                event_o,
    output logic                wkup_o
);

    typedef enum logic [2:0] {
        POSEDGE    = 3'd0,
        NEGEDGE    = 3'd1,
        ANYEDGE    = 3'd2,
        TIMED_HIGH = 3'd3,
        TIMED_LOW  = 3'd4
    } mode_e;

    localparam int SW = (FiltCycles > 2) ? $clog2(FiltCycles) : 1;
    localparam logic [SW-1:0] STAB_MAX = SW'(FiltCycles - 1);

    logic                sync1_q;
    logic                sync_q;
    logic [SW-1:0]       stab_q;
    logic [SW-1:0]       stab_d;
    logic                filt_q;
    logic                prev_q;
    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] cnt_d;
    logic [2:0]          mode_q;
    logic                event_d;
    logic                event_q;
    logic                wkup_q;
    logic [CntWidth-1:0] th;
    logic [CntWidth:0]   cnt_inc;
    logic                mode_chg;
    logic                target;
    mode_e               mode;

    assign mode     = mode_e'(mode_i);
    assign mode_chg = (mode_i != mode_q);
    assign th       = (cnt_th_i == '0) ? CntWidth'(1) : cnt_th_i;
    assign cnt_inc  = {1'b0, cnt_q} + {{CntWidth{1'b0}}, 1'b1};
    assign target   = (mode == TIMED_HIGH);

    // Stability count restarts when the sample entering sync_q differs
    always_comb begin
        stab_d = stab_q;
        if (sync1_q != sync_q) begin
            stab_d = '0;
        end else if (stab_q != STAB_MAX) begin
            stab_d = stab_q + SW'(1);
        end
    end

    always_comb begin
        event_d = 1'b0;
        cnt_d   = '0;
        if (en_i && !mode_chg) begin
            case (mode)
                POSEDGE: event_d = filt_q & ~prev_q;
                NEGEDGE: event_d = ~filt_q & prev_q;
                ANYEDGE: event_d = filt_q ^ prev_q;
                TIMED_HIGH, TIMED_LOW: begin
                    if (filt_q == target) begin
                        cnt_d   = (cnt_q < th) ? cnt_inc[CntWidth-1:0] : th;
                        event_d = (cnt_inc == {1'b0, th});
                    end
                end
                default: begin
                    event_d = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
            stab_q  <= '0;
            filt_q  <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= 3'd0;
            event_q <= 1'b0;
            wkup_q  <= 1'b0;
        end else begin
            sync1_q <= pad_i;
            sync_q  <= sync1_q;
            stab_q  <= stab_d;
            if (!filter_en_i || stab_q == STAB_MAX) begin
                filt_q <= sync_q;
            end
            prev_q  <= filt_q;
            cnt_q   <= cnt_d;
            mode_q  <= mode_i;
            event_q <= event_d;
            wkup_q  <= (wkup_q & ~clr_i) | event_q;
        end
    end

    assign event_o = event_q;
    assign wkup_o  = wkup_q;

endmodule

// File: tb/tb_pinmux_wkup_detector.sv
// Scoreboard bench: expected event cycles are queued when the pad is
// driven and matched against event_o pulses as they appear.
module tb_pinmux_wkup_detector;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       en;
    logic [2:0] mode;
    logic       filter_en;
    logic [7:0] cnt_th;
    logic       clr;
    logic       pad;
    logic       event_o;
    logic       wkup_o;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    int    q_at[$];
    string q_tag[$];

    pinmux_wkup_detector #(
        .CntWidth(8),
        .FiltCycles(4)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .en_i(en),
        .mode_i(mode),
        .filter_en_i(filter_en),
        .cnt_th_i(cnt_th),
        .clr_i(clr),
        .pad_i(pad),
        .event_o(event_o),
        .wkup_o(wkup_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input string tag, input int at);
        q_at.push_back(at);
        q_tag.push_back(tag);
    endtask

    always @(negedge clk) begin
        if (q_at.size() > 0 && q_at[0] < cyc) begin
            chk({q_tag[0], "_missed"}, cyc, q_at[0]);
            void'(q_at.pop_front());
            void'(q_tag.pop_front());
        end
        if (event_o) begin
            if (q_at.size() == 0) begin
                chk("spurious_ev", cyc, -1);
            end else begin
                chk(q_tag[0], cyc, q_at[0]);
                void'(q_at.pop_front());
                void'(q_tag.pop_front());
            end
        end
    end

    int base;

    initial begin
        en = 0; mode = 3'd0; filter_en = 0; cnt_th = 8'd0;
        clr = 0; pad = 0;
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        #2;
        chk("rst_event", int'(event_o), 0);
        chk("rst_wkup", int'(wkup_o), 0);
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        tick(2);

        // posedge, filter off
        en = 1; mode = 3'd0;
        tick(4);
        pad = 1;
        expect_ev("pos_rise", cyc + 4);
        tick(6);
        chk("pos_wkup", int'(wkup_o), 1);
        pad = 0;
        tick(8);
        clr = 1;
        tick(1);
        clr = 0;
        chk("clr_wkup", int'(wkup_o), 0);

        // debounce: glitch rejected, long pulse gives two edges
        en = 0; mode = 3'd2; filter_en = 1;
        tick(6);
        en = 1;
        tick(2);
        pad = 1;
        tick(3);
        pad = 0;
        tick(10);
        pad = 1;
        expect_ev("filt_rise", cyc + 7);
        tick(10);
        pad = 0;
        expect_ev("filt_fall", cyc + 7);
        tick(12);

        // timed high, threshold 5
        en = 0; mode = 3'd3; filter_en = 0; cnt_th = 8'd5;
        tick(6);
        en = 1;
        tick(2);
        pad = 1;
        expect_ev("timed_hi", cyc + 8);
        tick(20);
        pad = 0;
        tick(6);
        pad = 1;
        tick(4);
        pad = 0;
        tick(8);

        // timed low, threshold 0 acts as 1
        en = 0; pad = 1; mode = 3'd4; cnt_th = 8'd0;
        tick(6);
        en = 1;
        tick(3);
        pad = 0;
        expect_ev("th_zero", cyc + 4);
        tick(8);

        // set wins over clear in the same cycle
        en = 0; mode = 3'd0; pad = 0;
        tick(6);
        en = 1;
        tick(2);
        pad = 1;
        expect_ev("sticky_ev", cyc + 4);
        tick(4);
        clr = 1;
        tick(1);
        clr = 0;
        chk("set_wins", int'(wkup_o), 1);
        tick(1);
        clr = 1;
        tick(1);
        clr = 0;
        chk("clr_alone", int'(wkup_o), 0);

        // enabling with pad already high: no edge
        en = 0;
        tick(6);
        en = 1;
        tick(8);
        chk("en_high_wkup", int'(wkup_o), 0);

        // mode switch mid-count restarts the timer
        en = 0; mode = 3'd3; cnt_th = 8'd10; pad = 0;
        tick(6);
        en = 1;
        tick(2);
        pad = 1;
        base = cyc;
        tick(6);
        mode = 3'd4;
        tick(2);
        mode = 3'd3;
        expect_ev("mode_restart", base + 19);
        tick(16);
        pad = 0;
        tick(4);

        // async reset mid-count
        pad = 1;
        tick(8);
        rst_ni = 1'b0;
        #1;
        chk("midrst_event", int'(event_o), 0);
        chk("midrst_wkup", int'(wkup_o), 0);
        chk("midrst_cnt", int'(dut.cnt_q), 0);
        tick(2);
        rst_ni = 1'b1;
        expect_ev("post_rst", cyc + 13);
        tick(20);
        pad = 0;
        tick(4);

        chk("queue_empty", q_at.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
